psk_modulator: RTL and testbench
================================

// Module: psk_modulator
// PURPOSE
//  Parametrised BPSK/QPSK modulator: accepts parallel data words on a valid/ready
//  handshake, serialises them MSB-first into symbols and phase-shifts a LUT sine carrier.
//  Generalises the fixed 9-bit BPSK modulator with QPSK mode, configurable word and
//  symbol length, input back-pressure and output status. Feeds the transmit DAC path.
// PARAMETERS
//  DATA_WIDTH       12  signed sample width; LUT amplitude = 2^(DATA_WIDTH-1)-1
//  ADDR_WIDTH       8   sine LUT address width; 2^ADDR_WIDTH samples per carrier period
//  WORD_WIDTH       9   bits per input word (any value >= 1)
//  PERIODS_PER_SYM  1   carrier periods per symbol (>= 1)
// PORTS
//  clk         in   1           clock
//  arst_n      in   1           reset, synchronous, active-low
//  en          in   1           clock enable; low freezes all state and outputs
//  mode        in   1           0 = BPSK (1 bit/symbol), 1 = QPSK (2 bits/symbol)
//  in_data     in   WORD_WIDTH  data word
//  in_valid    in   1           in_data valid
//  in_ready    out  1           one-word holding register empty
//  signal_out  out  DATA_WIDTH  signed modulated sample
//  out_valid   out  1           signal_out carries a modulated sample
//  sym_start   out  1           aligned with first sample of each symbol
//  underrun    out  1           1-cycle pulse: word finished, no next word held
// BEHAVIOUR
//  - Reset (arst_n=0 at posedge): in_ready=1, signal_out=0, out_valid=0,
//    sym_start=0, underrun=0; holding reg empty; FSM=IDLE; counters=0.
//    Reset mid-word discards the word and any held word.
//  - en=0: no handshake (in_ready forced 0), counters, FSM and outputs hold.
//  - Handshake: word accepted when in_valid && in_ready (cycle T); stored in holding reg.
//  - FSM IDLE -> RUN when holding reg full: word moves to shift reg, mode latched,
//    sine_cnt=0, period_cnt=0; holding reg freed (in_ready=1 next cycle).
//  - RUN: sine_cnt +1 per enabled cycle, wraps mod 2^ADDR_WIDTH; on wrap period_cnt +1.
//    Symbol ends when sine_cnt wraps with period_cnt = PERIODS_PER_SYM-1.
//  - Symbol: BPSK bit b -> offset b * 2^(ADDR_WIDTH-1). QPSK Gray dibit 00/01/11/10
//    -> offset 0/1/2/3 * 2^(ADDR_WIDTH-2). Odd WORD_WIDTH in QPSK: last symbol padded
//    with LSB 0. LUT address = (sine_cnt + offset) mod 2^ADDR_WIDTH.
//  - Word end: if holding reg full, next word loads with no gap (continuous carrier,
//    its mode latched then); else underrun pulses, FSM -> IDLE.
//  - Mode changes mid-word are ignored until next load.
//  - Pipeline: address reg + ROM output reg; samples, out_valid, sym_start appear
//    2 cycles after their address. Idle first sample: 3 cycles after acceptance.
//  - out_valid=0 => signal_out=0. LUT: full-period sine, round-to-nearest,
//    sample k = round(A*sin(2*pi*k/2^ADDR_WIDTH)).
//  - Word duration: ceil(WORD_WIDTH/bps) * PERIODS_PER_SYM * 2^ADDR_WIDTH cycles.
// TESTING (defaults unless stated)
//  1 Reset: hold arst_n=0 4 cycles, random inputs -> in_ready=1, signal_out=0,
//    out_valid=0, underrun=0.
//  2 BPSK word 9'b1_0000_0000 -> first symbol: sample 64 = -2047, sample 192 = +2047;
//    symbols 2..9: sample 64 = +2047; sym_start every 256 cycles; underrun 1 cycle after
//    last sample.
//  3 QPSK, word 9'b01_11_10_00_0 -> 5 symbols; sine_cnt=0 samples 2047, 0, -2047, 0, 0
//    (offsets 64/128/192/0/0).
//  4 Back-to-back: second word with in_valid held during first -> accepted 1 cycle after
//    first load; out_valid continuous across words; no underrun between.
//  5 en=0 for 10 cycles mid-symbol -> signal_out, counters frozen; resumes same sample
//    sequence, total duration +10 cycles.
//  6 Reset asserted mid-word with a word held -> outputs to reset values next cycle;
//    no residual output after release; next word starts sine_cnt=0.

Source files
------------

// File: rtl/psk_if.sv
// Handshake and sample-output bundle between a word source and the PSK modulator.
interface psk_if #(
   parameter int DATA_WIDTH = 12,
   parameter int WORD_WIDTH = 9
);
   logic [WORD_WIDTH-1:0]        in_data;
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] signal_out;
   logic                         out_valid;
   logic                         sym_start;
   logic                         underrun;

   modport master (
      output in_data, in_valid,
      input  in_ready, signal_out, out_valid, sym_start, underrun
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, signal_out, out_valid, sym_start, underrun
   );
endinterface

// File: rtl/psk_modulator.sv
// BPSK/QPSK modulator: one-word holding register, MSB-first symbol serialiser and
// phase-offset addressing of a full-period sine LUT, two-stage output pipeline.
module psk_modulator #(
   parameter int DATA_WIDTH      = 12,
   parameter int ADDR_WIDTH      = 8,
   parameter int WORD_WIDTH      = 9,
   parameter int PERIODS_PER_SYM = 1
) (
   input  logic   clk,
   input  logic   arst_n,
   input  logic   en,
   input  logic   mode,
   psk_if.slave   bus
);
   // Handshake: a word transfers on a posedge where in_valid && in_ready; in_ready
   // is high only while enabled and the holding register is empty, and in_valid
   // must hold its data until that edge.
   localparam int N_SAMP = 1 << ADDR_WIDTH;
   localparam int AMP    = (1 << (DATA_WIDTH - 1)) - 1;
   localparam int PW     = (PERIODS_PER_SYM > 1) ? $clog2(PERIODS_PER_SYM) : 1;
   localparam int SW     = WORD_WIDTH + 1;
   localparam int CW     = $clog2(WORD_WIDTH + 1);
   localparam logic [CW-1:0] LAST_B = CW'(WORD_WIDTH - 1);
   localparam logic [CW-1:0] LAST_Q = CW'((WORD_WIDTH + 1) / 2 - 1);
   localparam logic [PW-1:0] LAST_P = PW'(PERIODS_PER_SYM - 1);
   localparam real PI = 3.14159265358979323846;

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic signed [DATA_WIDTH-1:0] sine_val(input int k);
      real x;
      int  r;
      x = real'(AMP) * $sin(2.0 * PI * real'(k) / real'(N_SAMP));
      r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
      return r[DATA_WIDTH-1:0];
   endfunction

   logic signed [DATA_WIDTH-1:0] lut [N_SAMP];
   for (genvar k = 0; k < N_SAMP; k++) begin : g_lut
      localparam logic signed [DATA_WIDTH-1:0] V = sine_val(k);
      assign lut[k] = V;
   end

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   sine_q, sine_d;
   logic [PW-1:0]           period_q, period_d;
   logic [CW-1:0]           sym_q, sym_d;
   logic [SW-1:0]           shift_q, shift_d;
   logic                    mode_q, mode_d;
   logic                    hold_full_q, hold_full_d;
   logic [WORD_WIDTH-1:0]   hold_data_q, hold_data_d;

   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    v1_q, ss1_q, ur1_q;
   logic signed [DATA_WIDTH-1:0] sample_q;
   logic                    ov_q, ss_q, ur2_q, ur_q;

   logic                    run, sym_end, word_end, last_sym, accept, load;
   logic [1:0]              dibit;
   logic [ADDR_WIDTH-1:0]   offset, addr_d;

   assign run      = (state_q == RUN);
   assign last_sym = (sym_q == (mode_q ? LAST_Q : LAST_B));
   assign sym_end  = run && (&sine_q) && (period_q == LAST_P);
   assign word_end = sym_end && last_sym;
   assign accept   = en && !hold_full_q && bus.in_valid;
   assign load     = hold_full_q && (!run || word_end);

   // The shift register carries a trailing zero so an odd word pads its last dibit.
   assign dibit  = shift_q[SW-1 -: 2];
   assign offset = mode_q ? (ADDR_WIDTH'({dibit[1], dibit[1] ^ dibit[0]}) << (ADDR_WIDTH - 2))
                          : (ADDR_WIDTH'(shift_q[SW-1]) << (ADDR_WIDTH - 1));
   assign addr_d = sine_q + offset;

   always_comb begin
      state_d     = state_q;
      sine_d      = sine_q;
      period_d    = period_q;
      sym_d       = sym_q;
      shift_d     = shift_q;
      mode_d      = mode_q;
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      case (state_q)
         IDLE: if (hold_full_q) state_d = RUN;
         RUN: begin
            if (word_end && !hold_full_q) state_d = IDLE;
            sine_d = sine_q + 1'b1;
            if (&sine_q) period_d = (period_q == LAST_P) ? '0 : period_q + 1'b1;
            if (sym_end) begin
               sym_d   = sym_q + 1'b1;
               shift_d = mode_q ? (shift_q << 2) : (shift_q << 1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         sine_d      = '0;
         period_d    = '0;
         sym_d       = '0;
         shift_d     = {hold_data_q, 1'b0};
         mode_d      = mode;
         hold_full_d = 1'b0;
      end
      if (accept) begin
         hold_full_d = 1'b1;
         hold_data_d = bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         sine_q      <= '0;
         period_q    <= '0;
         sym_q       <= '0;
         shift_q     <= '0;
         mode_q      <= 1'b0;
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         addr_q      <= '0;
         v1_q        <= 1'b0;
         ss1_q       <= 1'b0;
         ur1_q       <= 1'b0;
         sample_q    <= '0;
         ov_q        <= 1'b0;
         ss_q        <= 1'b0;
         ur2_q       <= 1'b0;
         ur_q        <= 1'b0;
      end else if (en) begin
         state_q     <= state_d;
         sine_q      <= sine_d;
         period_q    <= period_d;
         sym_q       <= sym_d;
         shift_q     <= shift_d;
         mode_q      <= mode_d;
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         addr_q      <= addr_d;
         v1_q        <= run;
         ss1_q       <= run && (sine_q == '0) && (period_q == '0);
         ur1_q       <= word_end && !hold_full_q;
         sample_q    <= v1_q ? lut[addr_q] : '0;
         ov_q        <= v1_q;
         ss_q        <= ss1_q;
         ur2_q       <= ur1_q;
         // Extra stage places the underrun pulse one cycle after the last sample.
         ur_q        <= ur2_q;
      end
   end

   assign bus.in_ready   = en && !hold_full_q;
   assign bus.signal_out = sample_q;
   assign bus.out_valid  = ov_q;
   assign bus.sym_start  = ss_q;
   assign bus.underrun   = ur_q;
endmodule

// File: tb/tb_psk_modulator.sv
// Directed and randomized checks of psk_modulator against a cycle-indexed model of
// the expected sample stream, handshake readiness and underrun pulses.
module tb_psk_modulator;
   localparam int DW = 12;
   localparam int AW = 8;
   localparam int WW = 9;
   localparam int PPS = 1;
   localparam int N = 1 << AW;
   localparam int SYM_LEN = N * PPS;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic en = 1'b1;
   logic mode = 1'b0;

   psk_if #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) bus ();

   psk_modulator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .PERIODS_PER_SYM(PPS)) dut (
      .clk(clk), .arst_n(arst_n), .en(en), .mode(mode), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int edge_n;
      logic signed [DW-1:0] val;
      logic ss;
   } exp_t;

   exp_t exp_q[$];
   int ur_list[$];
   int n_cmp = 0, n_mis = 0;
   int edge_cnt = 0, last_end = 0, last_acc = 0, hold_a = 0, hold_l = 0;
   bit started = 0, counted = 0, reset_edge = 0, have_prev = 0, ur_armed = 0, hold_valid = 0;
   logic signed [DW-1:0] e_val = '0;
   logic e_ov = 0, e_ss = 0, e_ur = 0;
   int gray_idx[4] = '{0, 1, 3, 2};

   function automatic int ref_sine(input int k);
      real x;
      x = (2.0 ** (DW - 1) - 1.0) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(N));
      return int'(x);
   endfunction

   function automatic bit ready_at(input int t);
      return !(hold_valid && t > hold_a && t <= hold_l);
   endfunction

   // Expected samples for a word accepted at enabled edge a.
   function automatic void accept(input int a, input logic [WW-1:0] w, input logic m);
      int nsym, l, off, b1, b0;
      logic [WW:0] padded;
      exp_t e;
      padded = {w, 1'b0};
      nsym = m ? (WW + 1) / 2 : WW;
      if (have_prev && a < last_end) begin
         l = last_end;
         ur_armed = 0;
      end else begin
         if (ur_armed && a <= last_end + 2) ur_list.push_back(last_end + 2);
         l = a + 1;
      end
      for (int s = 0; s < nsym; s++) begin
         if (m) begin
            b1 = int'(padded[WW - 2 * s]);
            b0 = int'(padded[WW - 1 - 2 * s]);
            off = gray_idx[b1 * 2 + b0] * (N / 4);
         end else begin
            off = int'(padded[WW - s]) * (N / 2);
         end
         for (int p = 0; p < PPS; p++)
            for (int k = 0; k < N; k++) begin
               e.edge_n = l + 2 + s * SYM_LEN + p * N + k;
               e.val = DW'(ref_sine((k + off) % N));
               e.ss = (p == 0 && k == 0);
               exp_q.push_back(e);
            end
      end
      last_end = l + nsym * SYM_LEN;
      ur_armed = 1;
      have_prev = 1;
      hold_a = a;
      hold_l = l;
      hold_valid = 1;
      last_acc = a;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
      end
   endtask

   // Model step on every posedge: count enabled edges and register acceptances.
   initial forever begin
      @(posedge clk);
      if (!arst_n) begin
         exp_q.delete();
         ur_list.delete();
         have_prev = 0; ur_armed = 0; hold_valid = 0;
         reset_edge = 1; counted = 0;
      end else if (en) begin
         edge_cnt++;
         counted = 1; reset_edge = 0;
         if (bus.in_valid && ready_at(edge_cnt)) accept(edge_cnt, bus.in_data, mode);
      end else begin
         counted = 0; reset_edge = 0;
      end
      started = 1;
   end

   // Scoreboard on every negedge.
   initial forever begin
      @(negedge clk);
      if (started) begin
         if (reset_edge) begin
            e_ov = 0; e_val = '0; e_ss = 0; e_ur = 0;
         end else if (counted) begin
            e_ov = 0; e_val = '0; e_ss = 0; e_ur = 0;
            if (exp_q.size() > 0 && exp_q[0].edge_n == edge_cnt) begin
               e_ov = 1; e_val = exp_q[0].val; e_ss = exp_q[0].ss;
               void'(exp_q.pop_front());
            end
            if (ur_list.size() > 0 && ur_list[0] == edge_cnt) begin
               e_ur = 1;
               void'(ur_list.pop_front());
            end else if (ur_armed && last_end + 2 == edge_cnt) e_ur = 1;
         end
         check("mon_out_valid", bus.out_valid, e_ov);
         check("mon_signal_out", bus.signal_out, e_val);
         check("mon_sym_start", bus.sym_start, e_ss);
         check("mon_underrun", bus.underrun, e_ur);
         check("mon_in_ready", bus.in_ready, en && ready_at(edge_cnt + 1));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_edge(input int t);
      int budget = 0;
      while (edge_cnt < t && budget < 30000) begin
         step();
         budget++;
      end
      if (edge_cnt != t) check("wait_edge_timeout", edge_cnt, t);
      @(negedge clk);
   endtask

   task automatic send_word(input logic [WW-1:0] w, input logic m, output int a);
      int budget = 0;
      while (!ready_at(edge_cnt + 1) && budget < 30000) begin
         step();
         budget++;
      end
      bus.in_data = w;
      mode = m;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      a = last_acc;
   endtask

   int a1, a2, a3;
   int q_exp[5] = '{2047, 0, -2047, 0, 0};

   initial begin
      bus.in_data = '0;
      bus.in_valid = 1'b0;

      // Reset with random inputs
      arst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_data = WW'($urandom);
         mode = 1'($urandom_range(0, 1));
         step();
      end
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_signal_out", bus.signal_out, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_underrun", bus.underrun, 0);
      bus.in_valid = 1'b0;
      arst_n = 1'b1;
      step(3);

      // BPSK single word
      send_word(9'b1_0000_0000, 1'b0, a1);
      wait_edge(a1 + 2);
      check("bpsk_pre_out_valid", bus.out_valid, 0);
      wait_edge(a1 + 3);
      check("bpsk_first_sym_start", bus.sym_start, 1);
      wait_edge(a1 + 3 + 64);
      check("bpsk_sym0_s64", bus.signal_out, -2047);
      wait_edge(a1 + 3 + 192);
      check("bpsk_sym0_s192", bus.signal_out, 2047);
      for (int s = 1; s < 9; s++) begin
         wait_edge(a1 + 3 + s * 256);
         check("bpsk_sym_start", bus.sym_start, 1);
         wait_edge(a1 + 3 + s * 256 + 64);
         check("bpsk_symN_s64", bus.signal_out, 2047);
      end
      wait_edge(a1 + 3 + 9 * 256 - 1);
      check("bpsk_last_valid", bus.out_valid, 1);
      wait_edge(a1 + 3 + 9 * 256);
      check("bpsk_underrun", bus.underrun, 1);
      check("bpsk_end_valid", bus.out_valid, 0);
      step(4);

      // QPSK Gray-coded word with odd length
      send_word(9'b01_11_10_00_0, 1'b1, a1);
      for (int s = 0; s < 5; s++) begin
         wait_edge(a1 + 3 + s * 256);
         check("qpsk_sym_start", bus.sym_start, 1);
         check("qpsk_cnt0_sample", bus.signal_out, q_exp[s]);
      end
      wait_edge(a1 + 3 + 5 * 256);
      check("qpsk_underrun", bus.underrun, 1);
      step(3);

      // Back-to-back words, mode toggled mid-word on the second
      send_word(WW'($urandom), 1'b0, a1);
      send_word(WW'($urandom), 1'b0, a2);
      check("b2b_accept_gap", a2 - a1, 2);
      wait_edge(a1 + 1 + 2 + 2303);
      check("b2b_last_valid", bus.out_valid, 1);
      wait_edge(a1 + 1 + 2 + 2304);
      check("b2b_next_valid", bus.out_valid, 1);
      check("b2b_next_sym_start", bus.sym_start, 1);
      check("b2b_no_underrun", bus.underrun, 0);
      step(300);
      mode = 1'b1;
      wait_edge(last_end + 4);
      mode = 1'b0;

      // Clock-enable freeze mid-symbol
      send_word(9'b10_01_11_00_1, 1'b1, a1);
      wait_edge(a1 + 3 + 100);
      check("en_before_freeze", bus.signal_out, ref_sine((100 + 192) % N));
      en = 1'b0;
      step(10);
      @(negedge clk);
      check("en_frozen_sample", bus.signal_out, ref_sine((100 + 192) % N));
      check("en_frozen_ready", bus.in_ready, 0);
      en = 1'b1;
      wait_edge(a1 + 3 + 101);
      check("en_resume_sample", bus.signal_out, ref_sine((101 + 192) % N));
      wait_edge(last_end + 4);

      // Reset mid-word with a second word held
      send_word(WW'($urandom), 1'b0, a1);
      send_word(WW'($urandom), 1'b0, a2);
      wait_edge(a1 + 500);
      arst_n = 1'b0;
      step();
      @(negedge clk);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_signal_out", bus.signal_out, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      arst_n = 1'b1;
      step(20);
      send_word(9'b0_0000_0001, 1'b0, a3);
      wait_edge(a3 + 3);
      check("postrst_sym_start", bus.sym_start, 1);
      check("postrst_sample0", bus.signal_out, 0);
      wait_edge(a3 + 3 + 64);
      check("postrst_sample64", bus.signal_out, 2047);
      wait_edge(last_end + 4);

      // Randomized words, modes and inter-word gaps
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 1) == 1) wait_edge(last_end + int'($urandom_range(0, 4)));
         send_word(WW'($urandom), 1'($urandom_range(0, 1)), a1);
      end
      wait_edge(last_end + 5);
      check("rand_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
